// File: rtl/cache_pkg.sv
// Shared types, line geometry and address helpers for the cache refill path.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN.
`ifndef RegBus
`define RegBus 32
`endif

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    DONE
  } refill_state_t;

  localparam int WORDS       = 4;
  localparam int OFF_W       = $clog2(WORDS);
  localparam int LINE_ADDR_W = 32;

  function automatic logic [LINE_ADDR_W-1:0] line_base(
    input logic [LINE_ADDR_W-1:0] addr
  );
    return addr & ~LINE_ADDR_W'(WORDS*4-1);
  endfunction

endpackage

// File: rtl/port_define.sv
// Global bus-width macros shared by the cache blocks.
// RegBus is the architectural register/data word width.
`ifndef RegBus
`define RegBus 32
`endif

// File: rtl/refill_beat_cnt.sv
// Modulo-WORDS beat counter: idx = start offset + beats seen, wrapping.
// last flags the final beat of the line.
module refill_beat_cnt
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             inc,
  output logic [OFF_W-1:0] idx,
  output logic             last
);

  logic [OFF_W-1:0] start_q;
  logic [OFF_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      start_q <= start;
      cnt_q   <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + OFF_W'(1);
    end
  end

  assign idx  = start_q + cnt_q;
  assign last = (cnt_q == OFF_W'(WORDS-1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss/refill controller feeding the DataMux B/S inputs.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN: wrapped burst, early delivery.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = `RegBus
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              stall,
  output logic              mux_sel,
  output logic [DATA_W-1:0] refill_word,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we
);

  refill_state_t state, state_nx;

  logic [ADDR_W-1:0] miss_q;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] req_addr;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  start;
  logic [OFF_W-1:0]  idx;
  logic              last;
  logic              accept;
  logic              beat;
  logic              hit;

  assign base   = ADDR_W'(line_base(LINE_ADDR_W'(miss_q)));
  assign off    = miss_q[OFF_W+1:2];
  assign accept = (state == IDLE) && miss_valid;
  assign beat   = (state == BURST) && mem_rvalid;
  assign hit    = beat && (idx == off);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign start    = miss_addr[OFF_W+1:2];
  assign req_addr = {miss_q[ADDR_W-1:2], 2'b00};
`else
  assign start    = '0;
  assign req_addr = base;
`endif

  refill_beat_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .start (start),
    .inc   (beat),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      miss_q <= '0;
      word_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) miss_q <= miss_addr;
      if (hit)    word_q <= mem_rdata;
    end
  end

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // deliver_q pulses the cycle after the critical beat; served_q marks the
  // pipeline as released while the rest of the line streams in.
  logic deliver_q;
  logic served_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliver_q <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      deliver_q <= hit;
      served_q  <= (state == BURST) && (served_q || deliver_q);
    end
  end
`endif

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mux_sel  = 1'b0;
    mem_req  = 1'b0;
    fill_we  = 1'b0;
    tag_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_valid) begin
          stall    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_nx = BURST;
      end
      BURST: begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        mux_sel = deliver_q;
        stall   = deliver_q ? 1'b0 : (served_q ? miss_valid : 1'b1);
`else
        stall   = 1'b1;
`endif
        fill_we = mem_rvalid;
        if (mem_rvalid && last) begin
          tag_we = 1'b1;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
          state_nx = IDLE;
`else
          state_nx = DONE;
`endif
        end
      end
      DONE: begin
`ifndef CACHE_CRITICAL_WORD_FIRST_EN
        mux_sel = 1'b1;
`endif
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr    = (state == REQ) ? req_addr : '0;
  assign fill_addr   = beat ? base + (ADDR_W'(idx) << 2) : '0;
  assign fill_data   = beat ? mem_rdata : '0;
  assign refill_word = word_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised self-checking bench for cache_refill_ctrl with a line-level
// memory model; expectations follow the miss/refill rules, in both builds.
module tb_cache_refill_ctrl;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int NW = 4;

  logic        clk;
  logic        rst_n;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        stall;
  logic        mux_sel;
  logic [31:0] refill_word;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        tag_we;

  cache_refill_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .stall       (stall),
    .mux_sel     (mux_sel),
    .refill_word (refill_word),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .tag_we      (tag_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory contents of the line under refill, indexed by word offset
  logic [31:0] line_d [NW];

  // observations of one refill
  logic [31:0] fa_q [$];
  logic [31:0] fd_q [$];
  bit          stall_tr [256];
  bit          miss_tr [256];
  int          ncyc, tag_cnt, tag_at_fill, tag_cyc, mux_cnt, mux_cyc;
  int          first_beat_cyc, last_beat_cyc, first_req_cyc, second_req_cyc;
  int          hs_cnt, req_addr_bad, fill_in_req;
  logic [31:0] mux_word, req_addr0, end_refill;
  logic [127:0] abort_out;
  bit          timeout;

  // ---- reference model: what the spec says a refill of addr looks like ----
  function automatic int start_word(input logic [31:0] a);
    return CWF ? int'(a[3:2]) : 0;
  endfunction

  function automatic logic [31:0] exp_fa(input logic [31:0] a, input int k);
    return (a & ~32'hF) + 32'((((start_word(a) + k) % NW)) * 4);
  endfunction

  function automatic logic [31:0] exp_fd(input logic [31:0] a, input int k);
    return line_d[(start_word(a) + k) % NW];
  endfunction

  function automatic logic [31:0] exp_mem_addr(input logic [31:0] a);
    return CWF ? (a & ~32'h3) : (a & ~32'hF);
  endfunction

  function automatic int exp_mux_cyc();
    return CWF ? first_beat_cyc + 1 : last_beat_cyc + 1;
  endfunction

  function automatic int stall_bad_cnt();
    int n = 0;
    for (int c = 0; c < ncyc; c++) begin
      bit e;
      e = (c < mux_cyc) ? 1'b1 : ((c == mux_cyc) ? 1'b0 : miss_tr[c]);
      if (stall_tr[c] != e) n++;
    end
    return n;
  endfunction

  function automatic int fill_bad_cnt(input logic [31:0] a);
    int n = 0;
    for (int k = 0; k < fa_q.size() && k < NW; k++) begin
      if (fa_q[k] !== exp_fa(a, k) || fd_q[k] !== exp_fd(a, k)) n++;
    end
    return n;
  endfunction

  task automatic set_line(input bit rnd);
    for (int i = 0; i < NW; i++)
      line_d[i] = rnd ? $urandom : 32'hA0 + 32'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one miss and plays the memory side; records what the DUT did.
  task automatic run_miss(input logic [31:0] addr, input int gnt_delay,
                          input int gap, input bit hold, input bit spur,
                          input int abort_beat);
    int  req_n = 0;
    bit  granted = 0;
    int  sent = 0;
    int  wait_n = 0;
    int  start = 0;
    int  extra = 0;
    fa_q.delete();
    fd_q.delete();
    ncyc = 0; tag_cnt = 0; tag_at_fill = 0; tag_cyc = -1;
    mux_cnt = 0; mux_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    first_req_cyc = -1; second_req_cyc = -1; hs_cnt = 0;
    req_addr_bad = 0; fill_in_req = 0; timeout = 1'b1;
    mux_word = '0; req_addr0 = '0; end_refill = '0; abort_out = '1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      miss_valid = (c == 0) || hold;
      miss_addr  = addr;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (granted && sent < NW) begin
        if (wait_n > 0) wait_n--;
        else begin
          mem_rvalid = 1'b1;
          mem_rdata  = line_d[(start + sent) % NW];
          if (abort_beat > 0 && sent == abort_beat - 1) begin
            miss_valid = 1'b0;
            rst_n      = 1'b0;
            #1;
            abort_out = {stall, mux_sel, refill_word, mem_req, mem_addr,
                         fill_we, fill_addr, tag_we, 28'd0} |
                        {96'd0, fill_data};
            timeout = 1'b0;
            ncyc = c;
            return;
          end
          sent++;
          if (sent == 1)  first_beat_cyc = c;
          if (sent == NW) last_beat_cyc = c;
          wait_n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        end
      end
      #1;
      if (mem_req) begin
        if (!granted) begin
          if (req_n == 0) begin
            first_req_cyc = c;
            req_addr0 = mem_addr;
          end else if (mem_addr !== req_addr0) req_addr_bad++;
          req_n++;
          if (spur && req_n == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
          end
          if (req_n > gnt_delay) begin
            mem_gnt = 1'b1;
            granted = 1'b1;
            hs_cnt++;
            start = int'(mem_addr[3:2]);
          end
        end else if (second_req_cyc < 0) second_req_cyc = c;
      end
      #1;
      stall_tr[c] = stall;
      miss_tr[c]  = miss_valid;
      if (fill_we) begin
        fa_q.push_back(fill_addr);
        fd_q.push_back(fill_data);
        if (mem_req) fill_in_req++;
      end
      if (tag_we) begin
        tag_cnt++;
        tag_at_fill = fa_q.size();
        tag_cyc = c;
      end
      if (mux_sel) begin
        mux_cnt++;
        mux_cyc  = c;
        mux_word = refill_word;
      end
      end_refill = refill_word;
      if (sent == NW && mux_cnt > 0 && tag_cnt > 0) begin
        extra++;
        if ((!hold && extra >= 2) ||
            (hold && (second_req_cyc >= 0 || extra >= 4))) begin
          ncyc = c + 1;
          timeout = 1'b0;
          return;
        end
      end
    end
    ncyc = 200;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    miss_valid = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({stall, mux_sel, refill_word, mem_req, mem_addr, fill_we,
         fill_addr, fill_data, tag_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b mux=%b rw=%h req=%b fill_we=%b tag=%b want all 0",
               stall, mux_sel, refill_word, mem_req, fill_we, tag_we);
    end
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({stall, mem_req, fill_we, mux_sel} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle got stall=%b req=%b fill_we=%b mux=%b want 0000",
               stall, mem_req, fill_we, mux_sel);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a = 32'h1008;
    do_reset();
    set_line(0);
    run_miss(a, 2, 0, 0, 0, 0);
    checks++;
    if (timeout) begin
      errors++; $display("FAIL basic_timeout got timeout want completion");
    end
    checks++;
    if (req_addr0 !== exp_mem_addr(a) || first_req_cyc != 1) begin
      errors++;
      $display("FAIL basic_req got addr=%h cyc=%0d want addr=%h cyc=1",
               req_addr0, first_req_cyc, exp_mem_addr(a));
    end
    checks++;
    if (fa_q.size() != NW || fill_bad_cnt(a) != 0) begin
      errors++;
      $display("FAIL basic_fill got n=%0d bad=%0d want n=4 bad=0",
               fa_q.size(), fill_bad_cnt(a));
    end
    checks++;
    if (tag_cnt != 1 || tag_at_fill != NW) begin
      errors++;
      $display("FAIL basic_tag got cnt=%0d at_beat=%0d want 1 at 4",
               tag_cnt, tag_at_fill);
    end
    checks++;
    if (mux_cnt != 1 || mux_cyc != exp_mux_cyc() || mux_word !== line_d[2]) begin
      errors++;
      $display("FAIL basic_mux got n=%0d cyc=%0d word=%h want 1 %0d %h",
               mux_cnt, mux_cyc, mux_word, exp_mux_cyc(), line_d[2]);
    end
    checks++;
    if (stall_bad_cnt() != 0 || req_addr_bad != 0) begin
      errors++;
      $display("FAIL basic_stall got bad_stall=%0d bad_req_addr=%0d want 0 0",
               stall_bad_cnt(), req_addr_bad);
    end
    checks++;
    if (end_refill !== line_d[2]) begin
      errors++;
      $display("FAIL basic_hold got %h want %h", end_refill, line_d[2]);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] a = 32'h1008;
    do_reset();
    set_line(0);
    run_miss(a, 2, 1, 0, 0, 0);
    checks++;
    if (timeout || fa_q.size() != NW || fill_bad_cnt(a) != 0) begin
      errors++;
      $display("FAIL gaps_fill got to=%0b n=%0d bad=%0d want 0 4 0",
               timeout, fa_q.size(), fill_bad_cnt(a));
    end
    checks++;
    if (stall_bad_cnt() != 0 || mux_cyc != exp_mux_cyc() || mux_word !== line_d[2]) begin
      errors++;
      $display("FAIL gaps_stall got bad=%0d cyc=%0d word=%h want 0 %0d %h",
               stall_bad_cnt(), mux_cyc, mux_word, exp_mux_cyc(), line_d[2]);
    end
  endtask

  task automatic test_crit_word();
    logic [31:0] a = 32'h100C;
    do_reset();
    set_line(0);
    run_miss(a, 1, 0, 0, 0, 0);
    checks++;
    if (timeout || req_addr0 !== exp_mem_addr(a)) begin
      errors++;
      $display("FAIL cwf_req got to=%0b addr=%h want 0 %h",
               timeout, req_addr0, exp_mem_addr(a));
    end
    checks++;
    if (fa_q.size() != NW || fill_bad_cnt(a) != 0 || fa_q[0] !== exp_fa(a, 0)) begin
      errors++;
      $display("FAIL cwf_fill got n=%0d bad=%0d want 4 0",
               fa_q.size(), fill_bad_cnt(a));
    end
    checks++;
    if (mux_cnt != 1 || mux_cyc != exp_mux_cyc() || mux_word !== 32'hA3) begin
      errors++;
      $display("FAIL cwf_mux got n=%0d cyc=%0d word=%h want 1 %0d a3",
               mux_cnt, mux_cyc, mux_word, exp_mux_cyc());
    end
    checks++;
    if (tag_cnt != 1 || tag_at_fill != NW || stall_bad_cnt() != 0) begin
      errors++;
      $display("FAIL cwf_tag got cnt=%0d at=%0d stall_bad=%0d want 1 4 0",
               tag_cnt, tag_at_fill, stall_bad_cnt());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a = 32'h2000;
    do_reset();
    set_line(0);
    run_miss(32'h1008, 1, 0, 0, 0, 2);
    checks++;
    if (abort_out !== '0) begin
      errors++;
      $display("FAIL abort_outputs got %h want 0", abort_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    set_line(1);
    run_miss(a, 1, 0, 0, 0, 0);
    checks++;
    if (timeout || req_addr0 !== 32'h2000 || first_req_cyc != 1) begin
      errors++;
      $display("FAIL abort_rerun_req got to=%0b addr=%h cyc=%0d want 0 2000 1",
               timeout, req_addr0, first_req_cyc);
    end
    checks++;
    if (fa_q.size() != NW || fill_bad_cnt(a) != 0 || mux_word !== line_d[0]) begin
      errors++;
      $display("FAIL abort_rerun_fill got n=%0d bad=%0d word=%h want 4 0 %h",
               fa_q.size(), fill_bad_cnt(a), mux_word, line_d[0]);
    end
  endtask

  task automatic test_miss_held();
    logic [31:0] a = 32'h1008;
    int want;
    do_reset();
    set_line(0);
    run_miss(a, 1, 0, 1, 0, 0);
    want = (CWF ? tag_cyc : mux_cyc) + 2;
    checks++;
    if (timeout || hs_cnt != 1) begin
      errors++;
      $display("FAIL held_handshake got to=%0b hs=%0d want 0 1", timeout, hs_cnt);
    end
    checks++;
    if (second_req_cyc != want) begin
      errors++;
      $display("FAIL held_second_req got cyc=%0d want %0d", second_req_cyc, want);
    end
    checks++;
    if (stall_bad_cnt() != 0 || fill_bad_cnt(a) != 0) begin
      errors++;
      $display("FAIL held_stall got stall_bad=%0d fill_bad=%0d want 0 0",
               stall_bad_cnt(), fill_bad_cnt(a));
    end
  endtask

  task automatic test_rvalid_in_req();
    logic [31:0] a = 32'h1004;
    do_reset();
    set_line(1);
    run_miss(a, 2, 0, 0, 1, 0);
    checks++;
    if (timeout || fill_in_req != 0) begin
      errors++;
      $display("FAIL req_rvalid_fill got to=%0b fills=%0d want 0 0",
               timeout, fill_in_req);
    end
    checks++;
    if (fa_q.size() != NW || fill_bad_cnt(a) != 0 || mux_word !== line_d[1]) begin
      errors++;
      $display("FAIL req_rvalid_seq got n=%0d bad=%0d word=%h want 4 0 %h",
               fa_q.size(), fill_bad_cnt(a), mux_word, line_d[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] a;
      a = $urandom & ~32'h3;
      set_line(1);
      run_miss(a, int'($urandom_range(0, 3)), -1, 0, 0, 0);
      checks++;
      if (timeout || req_addr0 !== exp_mem_addr(a) || fa_q.size() != NW ||
          fill_bad_cnt(a) != 0) begin
        errors++;
        $display("FAIL rand%0d_fill got to=%0b req=%h n=%0d bad=%0d want req=%h",
                 it, timeout, req_addr0, fa_q.size(), fill_bad_cnt(a),
                 exp_mem_addr(a));
      end
      checks++;
      if (mux_cnt != 1 || mux_cyc != exp_mux_cyc() ||
          mux_word !== line_d[a[3:2]] || stall_bad_cnt() != 0 ||
          tag_at_fill != NW) begin
        errors++;
        $display("FAIL rand%0d_deliver got cyc=%0d word=%h stall_bad=%0d tag_at=%0d want %0d %h 0 4",
                 it, mux_cyc, mux_word, stall_bad_cnt(), tag_at_fill,
                 exp_mux_cyc(), line_d[a[3:2]]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    miss_valid = 1'b0;
    miss_addr = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_crit_word();
    test_reset_mid_burst();
    test_miss_held();
    test_rvalid_in_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Cache miss/refill controller, directly upstream of the cache data-select mux (DataMux).
- On a miss, fetches one cache line from memory as a burst and writes each beat into the data array.
- Drives the mux select (S) and the refill word (B) so the pipeline receives the missed word in place of the array output (A).
- Stalls the pipeline until the missed word is delivered.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width; matches `RegBus
WORDS, 4, words per line; power of two, at least 2
OFF_W, $clog2(WORDS), word-offset bits in an address (address bits [OFF_W+1:2])

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  cache tag miss for the current access
miss_addr  in  ADDR_W  byte address of the missing access
stall  out  1  pipeline hold
mux_sel  out  1  to DataMux S; 1 selects refill_word
refill_word  out  DATA_W  to DataMux B; the missed word
mem_req  out  1  burst read request
mem_addr  out  ADDR_W  burst start byte address
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read beat valid
mem_rdata  in  DATA_W  read beat data
fill_we  out  1  data-array write strobe
fill_addr  out  ADDR_W  word-aligned array write address
fill_data  out  DATA_W  data-array write data
tag_we  out  1  tag/valid write strobe for the line

Behaviour:
Reset values:
- All outputs 0. State is IDLE. Beat counter is 0.
- Reset takes effect asynchronously, including mid-burst: any burst in progress is abandoned, and the memory side is reset with the same rst_n.

FSM states:
- IDLE: if miss_valid, latch miss_addr and go to REQ.
- REQ: mem_req=1 and mem_addr held stable until mem_gnt. On mem_gnt, go to BURST. mem_rvalid in REQ is ignored.
- BURST: each mem_rvalid beat produces, in the same cycle:
  - fill_we=1
  - fill_data=mem_rdata
  - fill_addr = line base + (word index × 4), where word index is modulo WORDS
  - the beat counter increments
- On the beat where the word index equals the missed offset, capture mem_rdata into the refill_word register.
- On the final beat (count = WORDS-1), also assert tag_we=1, then go to DONE.
- DONE: for exactly one cycle, mux_sel=1 and refill_word=captured word. stall deasserts in this cycle. Next state is IDLE.

Timing and stall:
- stall = (IDLE & miss_valid) | (state != IDLE & state != DONE). stall is combinational so the miss cycle itself is held.
- Latency: miss → mem_req is 1 cycle; last beat → mux_sel is 1 cycle.
- mem_rvalid gaps are allowed; the counter only advances on valid beats.

Boundary and conflict rules:
- miss_valid while not in IDLE is ignored; the pipeline is stalled, so no new miss can be presented.
- A miss may be accepted in the IDLE cycle immediately following DONE.
- refill_word holds its value outside DONE. mux_sel is 0 outside DONE.
- Counter wrap: the word index wraps from WORDS-1 to 0.

Optional Feature:
CACHE_CRITICAL_WORD_FIRST_EN
- Defined:
  - mem_addr is the missed word address, and the burst order wraps starting at the missed offset.
  - The first beat is the critical word. mux_sel=1 and refill_word are driven for one cycle, the cycle after that beat.
  - stall drops in that same cycle, while the remaining beats continue writing fill_* in the background.
  - A new miss_valid arriving before tag_we is ignored, and stall is re-asserted until the line completes.
- Undefined:
  - mem_addr is line-aligned and beats arrive in order 0..WORDS-1.
  - Delivery is as in Behaviour.

Decomposition:
- Shared package cache_pkg holds:
  - refill_state_t enum {IDLE, REQ, BURST, DONE}
  - constants WORDS and OFF_W
  - function line_base(addr)
- DATA_W comes from `RegBus in port_define.sv.
- One sub-module, refill_beat_cnt: modulo-WORDS counter with load-start-offset, inc, and last flag.

Test Plan:
All cases use WORDS=4; beat data d0..d3 = 0xA0, 0xA1, 0xA2, 0xA3, returned in address order.
1. Miss at 0x1008, feature off, mem_gnt after 2 cycles, 4 back-to-back beats:
   - mem_addr=0x1000.
   - fill_addr = 0x1000, 0x1004, 0x1008, 0x100C.
   - tag_we on beat 4.
   - mux_sel=1 with refill_word=0xA2 one cycle after the last beat; stall low in that same cycle.
2. As case 1 with one idle cycle between each beat:
   - Identical fill sequence.
   - stall held through the gaps.
3. Miss at 0x100C, feature on:
   - mem_addr=0x100C.
   - fill_addr = 0x100C, 0x1000, 0x1004, 0x1008.
   - mux_sel=1 with refill_word=0xA3 one cycle after beat 1.
   - tag_we on beat 4.
4. rst_n pulsed low during beat 2:
   - All outputs 0 immediately; state IDLE.
   - A subsequent miss at 0x2000 runs a clean burst with mem_addr=0x2000.
5. miss_valid held high through an entire refill:
   - Exactly one mem_req handshake.
   - A second miss is accepted only in the IDLE cycle after DONE.
6. mem_rvalid pulsed during REQ, before mem_gnt:
   - No fill_we.
   - Counter remains 0.
